instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the RV32I multi-cycle CPU: owns PC and instruction register (IR), feeds instr_code to the control unit.
//  On each pcen pulse it commits the next PC and fetches the instruction from instruction memory via a req/gnt/rvalid handshake.
//  Branch/jump redirects requested during Execution are captured and applied on the next pcen.
// PARAMETERS
//  RESET_PC    32'h0000_0000   PC value after reset; first fetched address
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  pcen           in   1   control-unit Fetch pulse: commit next PC, start fetch
//  pcSrcMuxSel    in   2   00 seq, 01 branch, 10 jump (JAL/JALR), 11 reserved
//  btaken         in   1   branch condition from ALU, qualifies pcSrcMuxSel=01
//  branch_target  in   32  PC+imm_B from datapath
//  jump_target    in   32  PC+imm_J or rs1+imm_I from datapath
//  imem_req       out  1   fetch request, held until imem_gnt
//  imem_addr      out  32  fetch address, = pc while imem_req high
//  imem_gnt       in   1   memory accepted request this cycle
//  imem_rvalid    in   1   imem_rdata valid (>=1 cycle after gnt)
//  imem_rdata     in   32  fetched instruction word
//  instr_code     out  32  IR contents
//  instr_valid    out  1   IR holds the instruction at pc
//  pc             out  32  PC of current instruction
//  pc_plus4       out  32  pc+4 (JAL/JALR link), comb, mod 2^32
//  fetch_busy     out  1   high in REQ/WAIT
//  misalign_fault out  1   sticky: a redirect target had [1:0]!=0
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, instr_code=32'h0000_0013 (NOP), instr_valid=0, imem_req=0,
//   redirect_pending=0, redirect_pc=0, started=0, misalign_fault=0.
//  FSM IDLE -> REQ -> WAIT -> IDLE.
//   IDLE: pcen=1 -> if started: pc <= redirect_pending ? redirect_pc : pc+4; else pc unchanged, started<=1.
//         redirect_pending<=0, instr_valid<=0, go REQ (same edge).
//   REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> WAIT.
//   WAIT: imem_rvalid=1 -> instr_code<=imem_rdata, instr_valid<=1, go IDLE.
//  Latency, gnt tied 1 and rvalid 1 cycle after gnt: pcen at edge N -> instr_valid high after edge N+2.
//  Redirect capture: only in IDLE with instr_valid=1, every cycle:
//   sel=01 & btaken -> redirect_pc<=branch_target; sel=10 -> redirect_pc<=jump_target; redirect_pending<=1.
//   sel=01 & !btaken, 00, 11 -> no change. Multiple captures before pcen: last wins.
//   Captured target bits [1:0] forced to 0; if original [1:0]!=0, misalign_fault<=1 (sticky until rst).
//  pcen outside IDLE: ignored (no PC change, no re-request). pcen and redirect in same cycle: pcen uses
//   previously latched redirect; same-cycle redirect is dropped.
//  imem_rvalid outside WAIT and imem_gnt outside REQ: ignored (covers stale responses after reset).
//  PC arithmetic 32-bit, wraps: 32'hFFFF_FFFC +4 -> 32'h0.
//  Reset mid-REQ/WAIT: request dropped immediately, all registers to reset values.
//  instr_code, pc stable between fetches; datapath/control may sample any time instr_valid=1.
// STRUCTURE
//  rv32_pkg: typedef enum {IF_IDLE, IF_REQ, IF_WAIT} fetch_state_e; PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01,
//   PC_SEL_JMP=2'b10; RV_NOP=32'h0000_0013.
//  Sub-module pc_redirect_latch: sel/btaken/targets -> redirect_pending, redirect_pc, misalign_fault.
//  FSM, PC and IR registers in the top.
// TESTING
//  1 rst, RESET_PC=0, gnt=1, rvalid +1 cycle, rdata=0x00500093; pcen -> imem_addr=0x0, instr_valid 2 edges later, instr_code=0x00500093.
//  2 second pcen, no redirect -> imem_addr=0x4, pc=0x4, pc_plus4=0x8.
//  3 sel=01,btaken=1,branch_target=0x40 -> next fetch 0x40; then sel=01,btaken=0 -> next fetch 0x44.
//  4 sel=10,jump_target=0x102 -> next fetch 0x100, misalign_fault=1 and stays 1 after later clean jumps.
//  5 gnt low 3 cycles, rvalid 2 cycles after gnt; extra pcen in WAIT -> fetch_busy high 5+ cycles, one fetch only, pc unchanged.
//  6 rst during WAIT then stray rvalid -> pc=RESET_PC, instr_code=0x13, instr_valid=0; seq from pc=0xFFFF_FFFC -> imem_addr=0x0.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared types and constants for the RV32I fetch stage
//
// Purpose: fetch FSM state encoding, PC source select codes and the NOP word
//          loaded into the instruction register on reset.
// Ports:   none (package).
package rv32_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  PC_SEL_SEQ = 2'b00;
  localparam logic [1:0]  PC_SEL_BR  = 2'b01;
  localparam logic [1:0]  PC_SEL_JMP = 2'b10;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;

endpackage

// File: rtl/pc_redirect_latch.sv
// rtl/pc_redirect_latch.sv - holds a pending branch/jump target until the next fetch
//
// Purpose: captures a taken branch or jump target while the fetch unit is idle
//          with a valid instruction, word-aligns it and flags misaligned targets.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   capture_en          fetch unit idle with a valid instruction
//   consume             fetch starting this cycle; clears pending, blocks capture
//   sel, btaken         PC source select and branch condition
//   branch_target       PC+imm_B
//   jump_target         PC+imm_J or rs1+imm_I
//   redirect_pending    a target is waiting to be applied
//   redirect_pc         aligned target to apply
//   misalign_fault      sticky: some captured target had [1:0] != 0
module pc_redirect_latch
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        consume,
  input  logic [1:0]  sel,
  input  logic        btaken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        redirect_pending,
  output logic [31:0] redirect_pc,
  output logic        misalign_fault
);

  logic        pending_q, pending_d;
  logic [31:0] rpc_q, rpc_d;
  logic        fault_q, fault_d;
  logic        take;
  logic [31:0] tgt;

  always_comb begin
    pending_d = pending_q;
    rpc_d     = rpc_q;
    fault_d   = fault_q;
    take      = 1'b0;
    tgt       = 32'h0;
    if (consume) begin
      // The starting fetch uses the previously latched target; a redirect
      // presented in the same cycle is dropped.
      pending_d = 1'b0;
    end else if (capture_en) begin
      if (sel == PC_SEL_BR && btaken) begin
        take = 1'b1;
        tgt  = branch_target;
      end else if (sel == PC_SEL_JMP) begin
        take = 1'b1;
        tgt  = jump_target;
      end
      if (take) begin
        pending_d = 1'b1;
        rpc_d     = {tgt[31:2], 2'b00};
        if (tgt[1:0] != 2'b00) fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      rpc_q     <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rpc_q     <= rpc_d;
      fault_q   <= fault_d;
    end
  end

  assign redirect_pending = pending_q;
  assign redirect_pc      = rpc_q;
  assign misalign_fault   = fault_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I multi-cycle fetch stage: PC, IR and imem handshake
//
// Purpose: on each pcen pulse commits the next PC (sequential or redirected)
//          and fetches the instruction over a req/gnt/rvalid interface.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   pcen                              commit next PC and start a fetch (IDLE only)
//   pcSrcMuxSel, btaken               redirect select and branch condition
//   branch_target, jump_target        redirect targets from the datapath
//   imem_req/addr, imem_gnt           request held until granted
//   imem_rvalid, imem_rdata           response, accepted only in WAIT
//   instr_code, instr_valid           instruction register and its valid flag
//   pc, pc_plus4                      current PC and its link value
//   fetch_busy                        high while a fetch is outstanding
//   misalign_fault                    sticky misaligned-redirect flag
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcen,
  input  logic [1:0]  pcSrcMuxSel,
  input  logic        btaken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_code,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        misalign_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         instr_valid_q, instr_valid_d;
  logic         started_q, started_d;
  logic         imem_req_q, imem_req_d;
  logic         fetch_busy_q, fetch_busy_d;

  logic         redirect_pending;
  logic [31:0]  redirect_pc;
  logic         capture_en;
  logic         consume;

  assign capture_en = (state_q == IF_IDLE) && instr_valid_q;
  assign consume    = (state_q == IF_IDLE) && pcen;

  pc_redirect_latch u_redirect (
    .clk              (clk),
    .rst              (rst),
    .capture_en       (capture_en),
    .consume          (consume),
    .sel              (pcSrcMuxSel),
    .btaken           (btaken),
    .branch_target    (branch_target),
    .jump_target      (jump_target),
    .redirect_pending (redirect_pending),
    .redirect_pc      (redirect_pc),
    .misalign_fault   (misalign_fault)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instr_valid_d = instr_valid_q;
    started_d     = started_q;
    case (state_q)
      IF_IDLE: begin
        if (pcen) begin
          // The very first fetch after reset uses RESET_PC itself.
          if (started_q) pc_d = redirect_pending ? redirect_pc : pc_plus4;
          started_d     = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = IF_REQ;
        end
      end
      IF_REQ: begin
        if (imem_gnt) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          ir_d          = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = IF_IDLE;
        end
      end
      default: state_d = IF_IDLE;
    endcase
    imem_req_d   = (state_d == IF_REQ);
    fetch_busy_d = (state_d != IF_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IF_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= RV_NOP;
      instr_valid_q <= 1'b0;
      started_q     <= 1'b0;
      imem_req_q    <= 1'b0;
      fetch_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
      started_q     <= started_d;
      imem_req_q    <= imem_req_d;
      fetch_busy_q  <= fetch_busy_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_code  = ir_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign fetch_busy  = fetch_busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcen;
  logic [1:0]  pc_sel;
  logic        btaken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_code;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_busy;
  logic        misalign_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcen           (pcen),
    .pcSrcMuxSel    (pc_sel),
    .btaken         (btaken),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_code     (instr_code),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_busy     (fetch_busy),
    .misalign_fault (misalign_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_redirect(input logic [1:0] s, input logic b,
                                input logic [31:0] br, input logic [31:0] jp);
    pc_sel        = s;
    btaken        = b;
    branch_target = br;
    jump_target   = jp;
    tick();
    pc_sel = 2'b00;
    btaken = 1'b0;
  endtask

  // One fetch: pcen for one cycle, grant after gnt_dly cycles, rvalid rv_dly
  // cycles after the grant. noisy holds pcen and a jump request throughout
  // REQ/WAIT; both must be ignored.
  task automatic do_fetch(input logic [31:0] exp_addr, input int gnt_dly,
                          input int rv_dly, input bit noisy);
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] gaddr;
    exp_addr_q.push_back(exp_addr);
    exp_data_q.push_back(mem_word(exp_addr));
    pcen = 1'b1;
    tick();
    if (noisy) begin
      pc_sel      = 2'b10;
      jump_target = 32'h0000_0900;
    end else begin
      pcen   = 1'b0;
      pc_sel = 2'b00;
    end
    chk("busy_in_req", {31'b0, fetch_busy}, 32'd1);
    chk("valid_low_in_req", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < gnt_dly; i++) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      tick();
    end
    chk("req_high", {31'b0, imem_req}, 32'd1);
    if (exp_addr_q.size() == 0) begin
      chk("addr_queue_empty", 32'd0, 32'd1);
      a = 32'h0;
    end else begin
      a = exp_addr_q.pop_front();
    end
    chk("imem_addr", imem_addr, a);
    gaddr    = imem_addr;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("req_dropped_in_wait", {31'b0, imem_req}, 32'd0);
    chk("busy_in_wait", {31'b0, fetch_busy}, 32'd1);
    chk("valid_low_in_wait", {31'b0, instr_valid}, 32'd0);
    for (int i = 1; i < rv_dly; i++) begin
      tick();
      chk("busy_wait_hold", {31'b0, fetch_busy}, 32'd1);
    end
    imem_rdata  = mem_word(gaddr);
    imem_rvalid = 1'b1;
    pcen        = 1'b0;
    pc_sel      = 2'b00;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (exp_data_q.size() == 0) begin
      chk("data_queue_empty", 32'd0, 32'd1);
      d = 32'h0;
    end else begin
      d = exp_data_q.pop_front();
    end
    chk("instr_code", instr_code, d);
    chk("instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("busy_done", {31'b0, fetch_busy}, 32'd0);
    chk("req_done", {31'b0, imem_req}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        bt;
    logic [31:0] br;
    logic [31:0] jp;
    int          gd;
    int          rd;
    logic [31:0] exp_addr;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 1'b0, 32'h0,         32'h0,   0, 1, 32'h0000_0000, 1'b0};
    vecs[1] = '{2'b00, 1'b0, 32'h0,         32'h0,   0, 1, 32'h0000_0004, 1'b0};
    vecs[2] = '{2'b01, 1'b1, 32'h40,        32'h0,   0, 1, 32'h0000_0040, 1'b0};
    vecs[3] = '{2'b01, 1'b0, 32'h80,        32'h0,   0, 1, 32'h0000_0044, 1'b0};
    vecs[4] = '{2'b10, 1'b0, 32'h0,         32'h102, 0, 1, 32'h0000_0100, 1'b1};
    vecs[5] = '{2'b10, 1'b0, 32'h0,         32'h200, 1, 1, 32'h0000_0200, 1'b1};
    vecs[6] = '{2'b11, 1'b1, 32'h300,       32'h300, 0, 1, 32'h0000_0204, 1'b1};
    vecs[7] = '{2'b00, 1'b0, 32'h0,         32'h0,   3, 2, 32'h0000_0208, 1'b1};
    vecs[8] = '{2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0,   0, 1, 32'hFFFF_FFFC, 1'b1};
    vecs[9] = '{2'b00, 1'b0, 32'h0,         32'h0,   0, 1, 32'h0000_0000, 1'b1};

    rst = 1'b1; pcen = 1'b0; pc_sel = 2'b00; btaken = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr_code", instr_code, 32'h0000_0013);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_fault", {31'b0, misalign_fault}, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      apply_redirect(vecs[v].sel, vecs[v].bt, vecs[v].br, vecs[v].jp);
      do_fetch(vecs[v].exp_addr, vecs[v].gd, vecs[v].rd, 1'b0);
      chk($sformatf("vec%0d_pc", v), pc, vecs[v].exp_addr);
      chk($sformatf("vec%0d_pc_plus4", v), pc_plus4, vecs[v].exp_addr + 32'd4);
      chk($sformatf("vec%0d_fault", v), {31'b0, misalign_fault}, {31'b0, vecs[v].exp_fault});
    end

    // Several captures before pcen: the last taken one wins.
    apply_redirect(2'b10, 1'b0, 32'h0,   32'h500);
    apply_redirect(2'b01, 1'b1, 32'h600, 32'h0);
    apply_redirect(2'b01, 1'b0, 32'h999, 32'h0);
    do_fetch(32'h0000_0600, 0, 1, 1'b0);
    chk("last_wins_pc", pc, 32'h0000_0600);

    // Redirect presented in the pcen cycle is dropped.
    pc_sel      = 2'b10;
    jump_target = 32'h0000_0700;
    do_fetch(32'h0000_0604, 0, 1, 1'b0);
    do_fetch(32'h0000_0608, 0, 1, 1'b0);

    // Extra pcen and jump request during a slow fetch: one fetch, pc steady.
    do_fetch(32'h0000_060C, 3, 2, 1'b1);
    chk("noisy_pc", pc, 32'h0000_060C);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("no_rerequest", {31'b0, imem_req}, 32'd0);
      chk("idle_after_noisy", {31'b0, fetch_busy}, 32'd0);
    end
    do_fetch(32'h0000_0610, 0, 1, 1'b0);

    // Reset while waiting for data, then a stale rvalid.
    pcen = 1'b1;
    tick();
    pcen     = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("pre_rst_busy", {31'b0, fetch_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_req", {31'b0, imem_req}, 32'd0);
    chk("async_rst_busy", {31'b0, fetch_busy}, 32'd0);
    chk("async_rst_code", instr_code, 32'h0000_0013);
    chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_rst_fault", {31'b0, misalign_fault}, 32'd0);
    tick();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_rvalid_valid", {31'b0, instr_valid}, 32'd0);
    chk("stale_rvalid_code", instr_code, 32'h0000_0013);
    chk("stale_rvalid_busy", {31'b0, fetch_busy}, 32'd0);
    do_fetch(32'h0000_0000, 0, 1, 1'b0);
    chk("post_rst_pc", pc, 32'h0);
    do_fetch(32'h0000_0004, 0, 1, 1'b0);
    chk("post_rst_fault", {31'b0, misalign_fault}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
